// File: rtl/adc_model_pkg.sv
// Shared types and helpers for the MCP300x/MCP320x SPI ADC model.
// Covers the frame states, the command-field positions and the differential clamp.
package adc_model_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_CMD,
        ST_NULL,
        ST_DATA_MSB,
        ST_DATA_LSB,
        ST_DONE
    } state_e;

    // Positions of the command fields, counted in sclk rises after the start bit
    localparam int unsigned CMD_SGL_POS = 0;
    localparam int unsigned CMD_SEL_POS = 1;

    function automatic int unsigned cmd_msbf_pos(input int unsigned ch_w);
        return CMD_SEL_POS + ch_w;
    endfunction

    function automatic logic [15:0] clamp_diff(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/adc_model_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with edge detection on the
// synchronised value. RST_VAL should match the pin's idle level.
module adc_model_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;
    assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/adc_spi_slave_model.sv
// MCP300x/MCP320x-style SPI ADC model that serves preloaded per-channel sample
// tables in mode (0,0). It oversamples the SPI pins on clk.
module adc_spi_slave_model
    import adc_model_pkg::*;
#(
    parameter int unsigned RES      = 10,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned CH_W     = $clog2(CHANNELS),
    parameter int unsigned ADDR_W   = $clog2(CHANNELS * DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_din,
    output logic              spi_dout,
    output logic              spi_dout_oe,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RES-1:0]    wr_data,
    output logic              conv_done,
    output logic [CH_W-1:0]   conv_ch,
    output logic              frame_abort
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned BIT_W    = $clog2(RES);
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MSBF_POS = cmd_msbf_pos(CH_W);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [1:0] din_sync_q;

    adc_model_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (spi_sclk),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    adc_model_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (spi_cs_n),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    // Same depth as the sclk synchroniser so din lines up with the detected rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_sync_q <= '0;
        else        din_sync_q <= {din_sync_q[0], spi_din};
    end

    logic [RES-1:0] mem_q [CHANNELS*DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    state_e             state_q;
    logic               sgl_q, msbf_q;
    logic [CH_W-1:0]    sel_q;
    logic [CNT_W-1:0]   cmd_cnt_q;
    logic [BIT_W-1:0]   bit_q;
    logic [RES-1:0]     sample_q;
    logic               dout_q, oe_q, done_q, abort_q;
    logic [CH_W-1:0]    conv_ch_q;
    logic [IDX_W-1:0]   ptr_q [CHANNELS];

    logic [CH_W-1:0]    sel_oth;
    logic [ADDR_W-1:0]  rd_addr, rd_addr_oth;
    logic [RES-1:0]     latch_d;

    assign sel_oth     = sel_q ^ CH_W'(1);
    assign rd_addr     = {sel_q, ptr_q[sel_q]};
    assign rd_addr_oth = {sel_oth, ptr_q[sel_oth]};

    // Asynchronous table read: a write landing on the latch cycle is not yet visible
    always_comb begin
        latch_d = mem_q[rd_addr];
        if (!sgl_q) latch_d = RES'(clamp_diff(16'(mem_q[rd_addr]), 16'(mem_q[rd_addr_oth])));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sgl_q     <= 1'b0;
            msbf_q    <= 1'b0;
            sel_q     <= '0;
            cmd_cnt_q <= '0;
            bit_q     <= '0;
            sample_q  <= '0;
            dout_q    <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            conv_ch_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) ptr_q[i] <= '0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (cs_rise) begin
                // Leaving DATA_MSB always means D0 was never driven
                if (state_q inside {ST_WAIT_START, ST_CMD, ST_NULL, ST_DATA_MSB}) abort_q <= 1'b1;
                state_q <= ST_IDLE;
                oe_q    <= 1'b0;
                dout_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: if (cs_fall) state_q <= ST_WAIT_START;
                    ST_WAIT_START: begin
                        if (sclk_rise && din_sync_q[1]) begin
                            cmd_cnt_q <= '0;
                            state_q   <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
                            if (cmd_cnt_q == CNT_W'(CMD_SGL_POS)) begin
                                sgl_q <= din_sync_q[1];
                            end else if (cmd_cnt_q < CNT_W'(MSBF_POS)) begin
                                sel_q <= CH_W'({sel_q, din_sync_q[1]});
                            end else begin
                                msbf_q   <= din_sync_q[1];
                                sample_q <= latch_d;
                                state_q  <= ST_NULL;
                            end
                        end
                    end
                    ST_NULL: begin
                        if (sclk_fall) begin
                            oe_q    <= 1'b1;
                            dout_q  <= 1'b0;
                            bit_q   <= BIT_W'(RES - 1);
                            state_q <= ST_DATA_MSB;
                        end
                    end
                    ST_DATA_MSB: begin
                        if (sclk_fall) begin
                            dout_q <= sample_q[bit_q];
                            if (bit_q == '0) begin
                                done_q       <= 1'b1;
                                conv_ch_q    <= sel_q;
                                ptr_q[sel_q] <= ptr_q[sel_q] + IDX_W'(1);
                                if (msbf_q) begin
                                    state_q <= ST_DONE;
                                end else begin
                                    bit_q   <= BIT_W'(1);
                                    state_q <= ST_DATA_LSB;
                                end
                            end else begin
                                bit_q <= bit_q - BIT_W'(1);
                            end
                        end
                    end
                    ST_DATA_LSB: begin
                        if (sclk_fall) begin
                            dout_q <= sample_q[bit_q];
                            if (bit_q == BIT_W'(RES - 1)) state_q <= ST_DONE;
                            else                          bit_q   <= bit_q + BIT_W'(1);
                        end
                    end
                    ST_DONE: if (sclk_fall) dout_q <= 1'b0;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi_dout    = dout_q;
    assign spi_dout_oe = oe_q;
    assign conv_done   = done_q;
    assign conv_ch     = conv_ch_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_adc_spi_slave_model.sv
// Directed bench for adc_spi_slave_model: a 10-bit/2-channel instance (A) and a
// 12-bit/4-channel/4-deep instance (B) with separate chip selects.
module tb_adc_spi_slave_model;

    localparam int HALF = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic din   = 1'b0;
    logic cs_a  = 1'b1;
    logic cs_b  = 1'b1;

    logic        dout_a, oe_a, done_a, abort_a;
    logic [0:0]  ch_a;
    logic        wr_en_a   = 1'b0;
    logic [4:0]  wr_addr_a = '0;
    logic [9:0]  wr_data_a = '0;

    logic        dout_b, oe_b, done_b, abort_b;
    logic [1:0]  ch_b;
    logic        wr_en_b   = 1'b0;
    logic [3:0]  wr_addr_b = '0;
    logic [11:0] wr_data_b = '0;

    int n_cmp, n_bad;
    int done_n_a, done_n_b, abort_n_a, abort_n_b;

    always #5 clk = ~clk;

    adc_spi_slave_model #(.RES(10), .CHANNELS(2), .DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_a), .spi_sclk(sclk), .spi_din(din),
        .spi_dout(dout_a), .spi_dout_oe(oe_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .conv_done(done_a), .conv_ch(ch_a), .frame_abort(abort_a)
    );

    adc_spi_slave_model #(.RES(12), .CHANNELS(4), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_b), .spi_sclk(sclk), .spi_din(din),
        .spi_dout(dout_b), .spi_dout_oe(oe_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .conv_done(done_b), .conv_ch(ch_b), .frame_abort(abort_b)
    );

    always @(negedge clk) begin
        if (done_a)  done_n_a++;
        if (done_b)  done_n_b++;
        if (abort_a) abort_n_a++;
        if (abort_b) abort_n_b++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr_drive(input int which, input logic en, input int addr, input int data);
        if (which == 0) begin
            wr_en_a = en; wr_addr_a = 5'(addr); wr_data_a = 10'(data);
        end else begin
            wr_en_b = en; wr_addr_b = 4'(addr); wr_data_b = 12'(data);
        end
    endtask

    task automatic wr(input int which, input int addr, input int data);
        @(negedge clk);
        wr_drive(which, 1'b1, addr, data);
        @(negedge clk);
        wr_drive(which, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One frame: leading zero, start, SGL, sel (MSB first), MSBF, then nclk
    // dout samples taken just before each master rise. An optional table write
    // is placed on the clk edge where the MSBF rise is acted on.
    task automatic frame(input int which, input logic sgl, input int sel, input logic msbf,
                         input int nclk, input logic col_en, input int col_addr, input int col_data,
                         output logic [63:0] rx, output logic oe_all);
        int   chw, ncmd;
        logic b;
        chw    = (which == 0) ? 1 : 2;
        ncmd   = chw + 4;
        rx     = '0;
        oe_all = 1'b1;
        @(negedge clk);
        if (which == 0) cs_a = 1'b0; else cs_b = 1'b0;
        for (int i = 0; i < ncmd; i++) begin
            if (i == 0)             b = 1'b0;
            else if (i == 1)        b = 1'b1;
            else if (i == 2)        b = sgl;
            else if (i == ncmd - 1) b = msbf;
            else                    b = sel[chw - 1 - (i - 3)];
            din = b;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (col_en && i == ncmd - 1) begin
                repeat (2) @(negedge clk);
                wr_drive(which, 1'b1, col_addr, col_data);
                @(negedge clk);
                wr_drive(which, 1'b0, 0, 0);
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
        din = 1'b0;
        for (int k = 0; k < nclk; k++) begin
            repeat (HALF) @(negedge clk);
            rx     = {rx[62:0], (which == 0) ? dout_a : dout_b};
            oe_all = oe_all & ((which == 0) ? oe_a : oe_b);
            if (k != nclk - 1) begin
                sclk = 1'b1;
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        if (which == 0) cs_a = 1'b1; else cs_b = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic conv(input string tag, input int which, input logic sgl, input int sel,
                        input logic msbf, input int nclk, input logic [63:0] exp,
                        input int exp_done, input int exp_abort,
                        input logic col_en, input int col_addr, input int col_data);
        logic [63:0] rx;
        logic        oe_all;
        int          d0, a0;
        d0 = (which == 0) ? done_n_a : done_n_b;
        a0 = (which == 0) ? abort_n_a : abort_n_b;
        frame(which, sgl, sel, msbf, nclk, col_en, col_addr, col_data, rx, oe_all);
        check_eq({tag, ".data"}, rx, exp);
        check_eq({tag, ".oe_on"}, 64'(oe_all), 64'(1));
        check_eq({tag, ".done"}, 64'(((which == 0) ? done_n_a : done_n_b) - d0), 64'(exp_done));
        check_eq({tag, ".abort"}, 64'(((which == 0) ? abort_n_a : abort_n_b) - a0), 64'(exp_abort));
        check_eq({tag, ".oe_off"}, 64'((which == 0) ? oe_a : oe_b), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst.dout_a",  64'(dout_a),  64'(0));
        check_eq("rst.oe_a",    64'(oe_a),    64'(0));
        check_eq("rst.done_a",  64'(done_a),  64'(0));
        check_eq("rst.ch_a",    64'(ch_a),    64'(0));
        check_eq("rst.abort_a", 64'(abort_a), 64'(0));
        check_eq("rst.oe_b",    64'(oe_b),    64'(0));
        check_eq("rst.ch_b",    64'(ch_b),    64'(0));

        // B: channel 2 holds 1..4; the fifth conversion wraps to index 0
        for (int i = 0; i < 4; i++) wr(1, 8 + i, i + 1);
        conv("wrap1", 1, 1'b1, 2, 1'b1, 15, 64'h001 << 2, 1, 0, 1'b0, 0, 0);
        check_eq("wrap1.ch", 64'(ch_b), 64'(2));
        conv("wrap2", 1, 1'b1, 2, 1'b1, 15, 64'h002 << 2, 1, 0, 1'b0, 0, 0);
        conv("wrap3", 1, 1'b1, 2, 1'b1, 15, 64'h003 << 2, 1, 0, 1'b0, 0, 0);
        conv("wrap4", 1, 1'b1, 2, 1'b1, 15, 64'h004 << 2, 1, 0, 1'b0, 0, 0);
        conv("wrap5", 1, 1'b1, 2, 1'b1, 15, 64'h001 << 2, 1, 0, 1'b0, 0, 0);

        // A: MSB-first only, then MSB-first followed by LSB-first
        wr(0, 0, 'h2A5);
        wr(0, 1, 'h2A5);
        conv("msbf1", 0, 1'b1, 0, 1'b1, 13, 64'h2A5 << 2, 1, 0, 1'b0, 0, 0);
        check_eq("msbf1.ch", 64'(ch_a), 64'(0));
        conv("msbf0", 0, 1'b1, 0, 1'b0, 22, 64'({10'h2A5, 9'b010010101, 2'b00}), 1, 0, 1'b0, 0, 0);

        // A: differential, including the clamp to zero
        do_reset();
        wr(0, 16, 'h100);
        wr(0, 0,  'h080);
        wr(0, 17, 'h100);
        conv("diff1", 0, 1'b0, 1, 1'b1, 13, 64'h080 << 2, 1, 0, 1'b0, 0, 0);
        check_eq("diff1.ch", 64'(ch_a), 64'(1));
        conv("diff0", 0, 1'b0, 0, 1'b1, 13, 64'h000, 1, 0, 1'b0, 0, 0);
        check_eq("diff0.ch", 64'(ch_a), 64'(0));

        // A: abort after four data bits, then the same sample is served again
        do_reset();
        conv("abort", 0, 1'b1, 1, 1'b1, 5, 64'b00100, 0, 1, 1'b0, 0, 0);
        conv("retry", 0, 1'b1, 1, 1'b1, 13, 64'h100 << 2, 1, 0, 1'b0, 0, 0);

        // A: write on the latch cycle returns the old value; new value seen next time
        wr(0, 0, 'h155);
        conv("coll_old", 0, 1'b1, 0, 1'b1, 13, 64'h155 << 2, 1, 0, 1'b1, 0, 'h3FF);
        do_reset();
        conv("coll_new", 0, 1'b1, 0, 1'b1, 13, 64'h3FF << 2, 1, 0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
